// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module : fetch_unit_pkg
// Brief  : Opcodes, FSM state encoding and reset PC shared by the fetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0020;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_next_pc_logic.sv
// ============================================================================
// Module : next_pc_logic
// Brief  : Combinational next-PC selection (sequential, beq/bne, j) and
//          self-jump detection.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module next_pc_logic
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic        alu_zero_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o,
  output logic        is_self_jump_o
);

  logic [5:0]  opcode;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        branch_taken;

  always_comb begin
    opcode        = instruction_i[31:26];
    pc_plus4_o    = pc_i + 32'd4;
    jump_target   = {pc_plus4_o[31:28], instruction_i[25:0], 2'b00};
    branch_target = pc_plus4_o + {{14{instruction_i[15]}}, instruction_i[15:0], 2'b00};
    branch_taken  = ((opcode == OP_BEQ) &&  alu_zero_i) ||
                    ((opcode == OP_BNE) && !alu_zero_i);

    next_pc_o = pc_plus4_o;
    if (opcode == OP_J) begin
      next_pc_o = jump_target;
    end else if (branch_taken) begin
      next_pc_o = branch_target;
    end

    // Only a j counts; a branch back onto itself keeps looping.
    is_self_jump_o = (opcode == OP_J) && (jump_target == pc_i);
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Program counter, RESET/RUN/HALT sequencing and retired-instruction
//          counter for the single-cycle datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   start_up,
  input  logic [31:0]            instruction,
  input  logic                   alu_zero,
  input  logic                   stall,
  output logic [31:0]            pc_out,
  output logic [31:0]            pc_plus4,
  output logic                   halted,
  output logic                   running,
  output logic [COUNT_WIDTH-1:0] inst_count
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [31:0] next_pc;
  logic        is_self_jump;

  next_pc_logic u_next_pc_logic (
    .pc_i           (pc_q),
    .instruction_i  (instruction),
    .alu_zero_i     (alu_zero),
    .pc_plus4_o     (pc_plus4),
    .next_pc_o      (next_pc),
    .is_self_jump_o (is_self_jump)
  );

  always_ff @(posedge clk) begin
    if (start_up) begin
      state_q <= RESET;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;

    unique case (state_q)
      RESET: begin
        state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          count_d = (&count_q) ? count_q : count_q + COUNT_ONE;
          if (is_self_jump) begin
            state_d = HALT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      HALT: begin
      end
      default: begin
        state_d = RESET;
      end
    endcase
  end

  assign pc_out     = pc_q;
  assign inst_count = count_q;
  assign halted     = (state_q == HALT);
  assign running    = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Self-checking bench for fetch_unit against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0020;

  logic        clk = 1'b0;
  logic        start_up, alu_zero, stall;
  logic [31:0] instruction;
  logic [31:0] pc_out, pc_plus4;
  logic        halted, running;
  logic [31:0] inst_count;

  // Secondary instances: wrapping reset PC and a narrow saturating counter.
  logic        su2;
  logic [31:0] w_pc_out, w_pc_plus4, w_cnt;
  logic        w_halted, w_running;
  logic [31:0] s_pc_out, s_pc_plus4;
  logic        s_halted, s_running;
  logic [2:0]  s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mst 0=reset 1=run 2=halt
  int          mst;
  logic [31:0] mpc;
  longint      mcnt;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .COUNT_WIDTH(32)) dut (
    .clk(clk), .start_up(start_up), .instruction(instruction),
    .alu_zero(alu_zero), .stall(stall), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .halted(halted), .running(running), .inst_count(inst_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .COUNT_WIDTH(32)) dut_wrap (
    .clk(clk), .start_up(su2), .instruction(32'h0000_0020),
    .alu_zero(1'b0), .stall(1'b0), .pc_out(w_pc_out), .pc_plus4(w_pc_plus4),
    .halted(w_halted), .running(w_running), .inst_count(w_cnt)
  );

  fetch_unit #(.RESET_PC(RPC), .COUNT_WIDTH(3)) dut_sat (
    .clk(clk), .start_up(su2), .instruction(32'h0000_0020),
    .alu_zero(1'b0), .stall(1'b0), .pc_out(s_pc_out), .pc_plus4(s_pc_plus4),
    .halted(s_halted), .running(s_running), .inst_count(s_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [31:0] ins, input logic z);
    logic [31:0] p4;
    int          off;
    p4  = pc + 32'd4;
    off = int'($signed(ins[15:0])) * 4;
    case (ins[31:26])
      6'd2:    return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      6'd4:    return z  ? p4 + 32'(off) : p4;
      6'd5:    return !z ? p4 + 32'(off) : p4;
      default: return p4;
    endcase
  endfunction

  task automatic model_edge(input logic su, input logic [31:0] ins, input logic z, input logic st);
    logic [31:0] t;
    if (su) begin
      mst = 0; mpc = RPC; mcnt = 0;
    end else if (mst == 0) begin
      mst = 1;
    end else if (mst == 1 && !st) begin
      t = model_target(mpc, ins, z);
      if (mcnt < 64'hFFFF_FFFF) mcnt++;
      if (ins[31:26] == 6'd2 && t == mpc) mst = 2;
      else mpc = t;
    end
  endtask

  task automatic step(input string tag, input logic su, input logic [31:0] ins,
                      input logic z, input logic st);
    start_up = su; instruction = ins; alu_zero = z; stall = st;
    model_edge(su, ins, z, st);
    @(posedge clk);
    #1;
    check_eq({tag, ".pc"},      pc_out,              mpc);
    check_eq({tag, ".pc4"},     pc_plus4,            mpc + 32'd4);
    check_eq({tag, ".cnt"},     inst_count,          32'(mcnt));
    check_eq({tag, ".halted"},  {31'd0, halted},     {31'd0, mst == 2});
    check_eq({tag, ".running"}, {31'd0, running},    {31'd0, mst == 1});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, saved_pc, saved_cnt;
    int          r;
    start_up = 1'b1; instruction = 32'h20; alu_zero = 1'b0; stall = 1'b0; su2 = 1'b1;
    mst = 0; mpc = RPC; mcnt = 0;

    // Reset then release
    step("rst0", 1, 32'h20, 0, 0);
    step("rst1", 1, 32'h20, 0, 0);
    check_eq("rst.pc_const", pc_out, 32'h0040_0020);
    step("rel", 0, 32'h20, 0, 0);
    check_eq("rel.pc_const", pc_out, 32'h0040_0020);
    check_eq("rel.cnt_const", inst_count, 32'd0);
    step("seq1", 0, 32'h20, 0, 0);
    check_eq("seq1.pc_const", pc_out, 32'h0040_0024);
    step("seq2", 0, 32'h20, 0, 0);
    check_eq("seq2.pc_const", pc_out, 32'h0040_0028);
    check_eq("seq2.cnt_const", inst_count, 32'd2);

    // Branches from 0x0040_0024
    step("br_rst", 1, 32'h20, 0, 0); step("br_rel", 0, 32'h20, 0, 0); step("br_a", 0, 32'h20, 0, 0);
    step("beq_t", 0, 32'h1000_0003, 1, 0);
    check_eq("beq_t.pc_const", pc_out, 32'h0040_0034);
    step("br_rst2", 1, 32'h20, 0, 0); step("br_rel2", 0, 32'h20, 0, 0); step("br_b", 0, 32'h20, 0, 0);
    step("beq_n", 0, 32'h1000_0003, 0, 0);
    check_eq("beq_n.pc_const", pc_out, 32'h0040_0028);
    step("br_c", 0, 32'h20, 0, 0); step("br_d", 0, 32'h20, 0, 0);
    step("bne_neg", 0, 32'h1400_FFFE, 0, 0);
    check_eq("bne_neg.pc_const", pc_out, 32'h0040_002C);
    step("bloop", 0, 32'h1000_FFFF, 1, 0);
    check_eq("bloop.pc_const", pc_out, 32'h0040_002C);
    check_eq("bloop.not_halt", {31'd0, halted}, 32'd0);

    // Stall, then self-jump under stall, then halt
    step("st_rst", 1, 32'h20, 0, 0); step("st_rel", 0, 32'h20, 0, 0);
    saved_pc = pc_out; saved_cnt = inst_count;
    for (int i = 0; i < 3; i++) step("stall", 0, 32'h20, 0, 1);
    check_eq("stall.pc_hold", pc_out, saved_pc);
    check_eq("stall.cnt_hold", inst_count, saved_cnt);
    step("unstall", 0, 32'h20, 0, 0); step("back", 0, 32'h0810_0008, 0, 0);
    check_eq("unstall.pc_const", pc_out, 32'h0040_0020);
    step("sj_stall", 0, 32'h0810_0008, 0, 1);
    check_eq("sj_stall.no_halt", {31'd0, halted}, 32'd0);
    saved_cnt = inst_count;
    step("sj", 0, 32'h0810_0008, 0, 0);
    check_eq("sj.halted", {31'd0, halted}, 32'd1);
    check_eq("sj.cnt", inst_count, saved_cnt + 32'd1);
    for (int i = 0; i < 4; i++) step("halt_hold", 0, $urandom, 1'($urandom), 1'($urandom));
    check_eq("halt_hold.pc", pc_out, 32'h0040_0020);
    step("halt_rst", 1, 32'h20, 0, 0);
    check_eq("halt_rst.pc", pc_out, RPC);

    // Reset mid-run at 0x0040_0100
    step("mr_rel", 0, 32'h20, 0, 0); step("mr_j", 0, 32'h0810_0040, 0, 0);
    check_eq("mr_j.pc", pc_out, 32'h0040_0100);
    step("mr_rst", 1, 32'h20, 0, 0);
    check_eq("mr_rst.cnt", inst_count, 32'd0);

    // Randomized run
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 9);
      ins = $urandom;
      case (r)
        0:       ins = {6'd2, 4'h0, 2'b01, ins[19:0]};
        1:       ins = {6'd2, ins[25:0]};
        2:       ins = {6'd2, mpc[27:2]};
        3, 4:    ins = {6'd4, ins[25:0]};
        5, 6:    ins = {6'd5, ins[25:0]};
        default: if (ins[31:26] == 6'd2 || ins[31:26] == 6'd4 || ins[31:26] == 6'd5) ins[31:26] = 6'd0;
      endcase
      step("rand", ($urandom_range(0, 39) == 0), ins, 1'($urandom), ($urandom_range(0, 4) == 0));
    end

    // Wrapping reset PC and 3-bit saturating counter
    su2 = 1'b1; @(posedge clk); @(posedge clk); #1;
    check_eq("wrap.pc_rst", w_pc_out, 32'hFFFF_FFFC);
    check_eq("wrap.pc4", w_pc_plus4, 32'h0000_0000);
    su2 = 1'b0; @(posedge clk); #1;
    check_eq("sat.rel_cnt", {29'd0, s_cnt}, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (i == 1) check_eq("wrap.next", w_pc_out, 32'h0000_0000);
      check_eq("sat.cnt", {29'd0, s_cnt}, (i > 7) ? 32'd7 : 32'(i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch/PC stage feeding the single-cycle processor datapath.
- Owns the program counter and computes the next PC: sequential, taken beq/bne, or j.
- Detects the end-of-program idiom (a jump to itself) and halts.
- Counts retired instructions for bench and debug visibility.
- Presents pc_out to instruction memory combinationally; takes back the fetched instruction word and the ALU zero flag.

Parameters:
- RESET_PC, 32'h0040_0020, PC value loaded on reset; first instruction address.
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- start_up  input  1  synchronous, active-high reset.
- instruction  input  32  instruction word read from memory at pc_out (same cycle).
- alu_zero  input  1  zero flag from the ALU for the current instruction.
- stall  input  1  hold PC this cycle; no retirement counted.
- pc_out  output  32  current PC.
- pc_plus4  output  32  pc_out + 4, modulo 2^32 (wraps 0xFFFF_FFFC -> 0).
- halted  output  1  high while in HALT state.
- running  output  1  high while in RUN state.
- inst_count  output  COUNT_WIDTH  number of retired instructions.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on start_up. Any edge with start_up=1 forces:
  - state = RESET
  - pc_out = RESET_PC
  - inst_count = 0
  - halted = 0, running = 0
  Reset overrides stall and takes effect from any state.
- States: RESET, RUN, HALT.
- RESET:
  - pc_out holds RESET_PC.
  - First edge with start_up=0 -> RUN. pc_out is unchanged on that edge and the count does not increment.
- RUN, edge with stall=1: pc_out and inst_count hold; state holds.
- RUN, edge with stall=0:
  - pc_out <= next_pc.
  - inst_count += 1, saturating at all-ones (no wrap).
- next_pc decode uses opcode = instruction[31:26]:
  - 6'b000010 (j): {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - 6'b000100 (beq) with alu_zero=1, or 6'b000101 (bne) with alu_zero=0: pc_plus4 + {sign_ext(instruction[15:0]), 2'b00}, modulo 2^32.
  - Untaken branch and all other opcodes: pc_plus4.
- Halt detection:
  - Condition: in RUN, stall=0, opcode is j, and the jump target equals pc_out.
  - On that edge: state -> HALT, pc_out unchanged, inst_count increments once (the self-jump counts as retired).
  - If stall=1 on the self-jump cycle, no halt occurs that cycle.
- HALT: pc_out, inst_count, and state hold. stall, instruction, and alu_zero are ignored. Exit only via start_up.
- Outputs are registered-state only: pc_out is combinationally equal to the PC register, and pc_plus4 is combinational from it. Zero-cycle latency from PC register to memory address.
- A branch with offset 0xFFFF (target = pc_out) is not a halt; it loops normally and counts each iteration.

Decomposition:
- Shared package: opcode constants OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101; the state enum {RESET, RUN, HALT}; RESET_PC default constant.
- One natural sub-module: next_pc_logic. Purely combinational: takes pc, instruction, and alu_zero; produces pc_plus4, next_pc, and is_self_jump.
- The FSM, PC register, and counter stay in fetch_unit.

Test Plan:
1. Reset then release:
   - Stimulus: start_up=1 for 2 edges, drop it; instruction = 32'h0000_0020 (add).
   - Required: pc_out = 0x0040_0020 through the release edge, then 0x0040_0024, 0x0040_0028; inst_count 0, 1, 2.
2. Branch taken/untaken:
   - Stimulus: at pc 0x0040_0024, instruction = 32'h1000_0003 (beq +3).
     - alu_zero=1 -> pc 0x0040_0034.
     - Repeat with alu_zero=0 -> pc 0x0040_0028.
   - Stimulus: bne 32'h1400_FFFE at pc 0x0040_0030 with alu_zero=0 -> pc 0x0040_002C (negative offset).
3. Jump and halt:
   - Stimulus: instruction = 32'h0810_0008 at pc 0x0040_0020.
   - Required: pc -> 0x0040_0020 (self-jump), halted=1 after that edge, inst_count frozen at its value +1.
   - Further edges with any stall/instruction change nothing.
4. Stall:
   - Stimulus: stall=1 for 3 edges in RUN.
   - Required: pc_out and inst_count unchanged; after release, advance resumes by 4.
   - Stimulus: self-jump presented with stall=1 -> no halt.
5. Reset mid-operation and wrap:
   - Stimulus: assert start_up while in RUN at pc 0x0040_0100, and separately while in HALT.
   - Required: next edge gives pc 0x0040_0020, count 0, state RESET.
   - Stimulus: with RESET_PC = 32'hFFFF_FFFC, a sequential instruction.
   - Required: pc_plus4 = 0 and next pc 0x0000_0000.
6. Counter saturation:
   - Stimulus: COUNT_WIDTH=3 and 9 non-stalled instructions.
   - Required: inst_count reaches 7 and holds at 7.
